// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, IFQ entry layout and reset PC.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IFQ entry layout, MSB to LSB: pc | inst | taken | target
  localparam int TARGET_LSB = 0;
  localparam int TAKEN_BIT  = TARGET_LSB + XLEN;
  localparam int INST_LSB   = TAKEN_BIT + 1;
  localparam int PC_LSB     = INST_LSB + XLEN;
  localparam int ENTRY_W    = PC_LSB + XLEN;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            taken;
    logic [XLEN-1:0] target;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush and occupancy output; used as the IFQ.
module fetch_queue #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[head];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, fills the IFQ from imem + predictor, restarts on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              IFQ_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [XLEN-1:0]                  imem_addr,
  input  logic [XLEN-1:0]                  imem_rdata,
  output logic [XLEN-1:0]                  bp_pc,
  input  logic                             bp_taken,
  input  logic [XLEN-1:0]                  bp_target,
  input  logic                             redirect,
  input  logic [XLEN-1:0]                  redirect_pc,
  input  logic                             deq_ready,
  output logic                             deq_valid,
  output logic [XLEN-1:0]                  deq_inst,
  output logic [XLEN-1:0]                  deq_pc,
  output logic                             deq_pred_taken,
  output logic [XLEN-1:0]                  deq_pred_target,
  output logic [$clog2(IFQ_DEPTH+1)-1:0]   ifq_count
);

  logic [XLEN-1:0]    pc;
  logic               full;
  logic               empty;
  logic               enq;
  logic               pop;
  ifq_entry_t         enq_entry;
  logic [ENTRY_W-1:0] head_data;

  assign imem_addr = pc;
  assign bp_pc     = pc;

  // Redirect blocks both sides so nothing enters or leaves the queue being flushed.
  assign enq       = !full && !redirect;
  assign deq_valid = !empty && !redirect;
  assign pop       = deq_valid && deq_ready;

  assign enq_entry = '{pc: pc, inst: imem_rdata, taken: bp_taken, target: bp_target};

  assign deq_pc          = head_data[PC_LSB +: XLEN];
  assign deq_inst        = head_data[INST_LSB +: XLEN];
  assign deq_pred_taken  = head_data[TAKEN_BIT];
  assign deq_pred_target = head_data[TARGET_LSB +: XLEN];

  always_ff @(posedge clk) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= align_pc(redirect_pc);
    else if (enq)      pc <= align_pc(bp_target);
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (IFQ_DEPTH)
  ) u_ifq (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (enq),
    .push_data (enq_entry),
    .pop       (pop),
    .head_data (head_data),
    .count     (ifq_count),
    .full      (full),
    .empty     (empty)
  );

endmodule
